// File: rtl/b64_pkg.sv
// Shared types and constants for the ASCII-to-base64 repacking controller.
package b64_pkg;

  localparam int CHAR_W = 7;
  localparam int SYM_W  = 6;
  localparam int BUF_W  = CHAR_W + SYM_W - 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    TAIL  = 2'd2
  } state_t;

  // Zero bits appended when the final symbol holds only cnt real bits.
  function automatic logic [2:0] pad_bits(input logic [CNT_W-1:0] cnt);
    return 3'(CNT_W'(SYM_W) - cnt);
  endfunction

endpackage

// File: rtl/b64_pack_ctrl.sv
// Repacks an MSB-first stream of 7-bit characters into 6-bit base64 indices,
// zero-padding the final partial symbol and flagging end of message.
module b64_pack_ctrl
  import b64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [SYM_W-1:0]  out_sym,
  output logic              out_last,
  output logic [2:0]        out_pad,
  input  logic              out_ready
);

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;

  logic [BUF_W-1:0]  char_al;
  logic [BUF_W-1:0]  buf_sh;
  logic [CNT_W-1:0]  cnt_sh;

  // Bits below cnt are always zero, so a new character is simply OR-ed in
  // right after the bits already held.
  assign char_al = {in_char, {(BUF_W-CHAR_W){1'b0}}};
  assign buf_sh  = buf_q << SYM_W;
  assign cnt_sh  = cnt_q - CNT_W'(SYM_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          buf_d   = buf_q | (char_al >> cnt_q);
          cnt_d   = cnt_q + CNT_W'(CHAR_W);
          flush_d = in_last;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          buf_d = buf_sh;
          cnt_d = cnt_sh;
          if (cnt_sh < CNT_W'(SYM_W)) begin
            if (!flush_q) begin
              state_d = FILL;
            end else if (cnt_sh == '0) begin
              state_d = FILL;
              flush_d = 1'b0;
            end else begin
              state_d = TAIL;
            end
          end
        end
      end
      TAIL: begin
        if (out_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          flush_d = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_sym   = '0;
    out_last  = 1'b0;
    out_pad   = '0;
    unique case (state_q)
      FILL: in_ready = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_sym   = buf_q[BUF_W-1 -: SYM_W];
        out_last  = flush_q && (cnt_q == CNT_W'(SYM_W));
      end
      TAIL: begin
        out_valid = 1'b1;
        out_sym   = buf_q[BUF_W-1 -: SYM_W];
        out_last  = 1'b1;
        out_pad   = pad_bits(cnt_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_b64_pack_ctrl.sv
// Directed bench for b64_pack_ctrl: a table of messages with hand-computed
// symbol streams, plus hand-written reset and mid-message reset sequences.
module tb_b64_pack_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [6:0] in_char;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_sym;
  logic       out_last;
  logic [2:0] out_pad;
  logic       out_ready;

  int total;
  int passed;

  // Characters and symbols are packed first-at-MSB.
  typedef struct packed {
    logic [2:0]  nch;
    logic [41:0] chs;
    logic [3:0]  nsym;
    logic [47:0] syms;
    logic [2:0]  pad;
    logic        stall;
  } vec_t;

  vec_t vecs [6];

  b64_pack_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sym   (out_sym),
    .out_last  (out_last),
    .out_pad   (out_pad),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sym"},   32'(out_sym),   32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_pad"},   32'(out_pad),   32'd0);
  endtask

  // Entered and left at a negedge; drives and samples only on negedges.
  task automatic run_vec(input vec_t v);
    int         ci;
    int         si;
    int         cyc;
    logic       accepted;
    logic       stalled;
    logic       rdy;
    logic [5:0] hs;
    logic       hl;
    logic [2:0] hp;
    logic [5:0] esym;
    ci = 0; si = 0; cyc = 0;
    accepted = 1'b0; stalled = 1'b0;
    hs = '0; hl = 1'b0; hp = '0;
    while (si < int'(v.nsym) && cyc < 200) begin
      if (accepted) chk("latency_out_valid", 32'(out_valid), 32'd1);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_sym",   32'(out_sym),   32'(hs));
        chk("stall_last",  32'(out_last),  32'(hl));
        chk("stall_pad",   32'(out_pad),   32'(hp));
      end
      chk("ready_excl", 32'(in_ready), 32'(!out_valid));
      accepted = 1'b0;
      if (ci < int'(v.nch)) begin
        in_valid = 1'b1;
        in_char  = v.chs[41-7*ci -: 7];
        in_last  = (ci == int'(v.nch) - 1);
        if (in_ready) begin
          accepted = 1'b1;
          ci++;
        end
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      rdy = (v.stall && (cyc % 3 != 2)) ? 1'b0 : 1'b1;
      out_ready = rdy;
      stalled = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          esym = v.syms[47-6*si -: 6];
          chk("sym",  32'(out_sym),  32'(esym));
          chk("last", 32'(out_last), 32'(si == int'(v.nsym) - 1));
          chk("pad",  32'(out_pad),  (si == int'(v.nsym) - 1) ? 32'(v.pad) : 32'd0);
          si++;
        end else begin
          stalled = 1'b1;
          hs = out_sym; hl = out_last; hp = out_pad;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("symbols_done", 32'(si), 32'(v.nsym));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk("end_out_valid", 32'(out_valid), 32'd0);
    chk("end_in_ready",  32'(in_ready),  32'd1);
  endtask

  initial begin
    total = 0; passed = 0;
    vecs[0] = '{nch: 3'd4, chs: {7'h41, 7'h42, 7'h43, 7'h44, 14'h0},
                nsym: 4'd5, syms: {6'd32, 6'd48, 6'd40, 6'd28, 6'd16, 18'h0},
                pad: 3'd2, stall: 1'b0};
    vecs[1] = '{nch: 3'd1, chs: {7'h41, 35'h0},
                nsym: 4'd2, syms: {6'd32, 6'd32, 36'h0},
                pad: 3'd5, stall: 1'b0};
    vecs[2] = '{nch: 3'd6, chs: {6{7'h41}},
                nsym: 4'd7, syms: {6'd32, 6'd48, 6'd24, 6'd12, 6'd6, 6'd3, 6'd1, 6'd0},
                pad: 3'd0, stall: 1'b0};
    vecs[3] = '{nch: 3'd4, chs: {7'h41, 7'h42, 7'h43, 7'h44, 14'h0},
                nsym: 4'd5, syms: {6'd32, 6'd48, 6'd40, 6'd28, 6'd16, 18'h0},
                pad: 3'd2, stall: 1'b1};
    vecs[4] = '{nch: 3'd2, chs: {7'h41, 7'h42, 28'h0},
                nsym: 4'd3, syms: {6'd32, 6'd48, 6'd32, 30'h0},
                pad: 3'd4, stall: 1'b0};
    vecs[5] = '{nch: 3'd3, chs: {7'h7F, 7'h7F, 7'h7F, 21'h0},
                nsym: 4'd4, syms: {6'd63, 6'd63, 6'd63, 6'd56, 24'h0},
                pad: 3'd3, stall: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_char = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Two characters of a message, then reset while a symbol is pending.
    in_valid = 1'b1; in_char = 7'h41; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_first_valid", 32'(out_valid), 32'd1);
    chk("mid_first_sym",   32'(out_sym),   32'd32);
    in_char = 7'h42;
    @(posedge clk); @(negedge clk);
    chk("mid_fill_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("mid_second_sym", 32'(out_sym), 32'd48);
    rst = 1'b1; in_valid = 1'b1; in_char = 7'h7F; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    run_vec(vecs[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
